// File: rtl/pwm_counter.sv
// -----------------------------------------------------------------------------
// pwm_counter
//
// Prescaled up/down period counter for PWM timebases. A prescaler divides clk
// into count ticks (one tick every prescale+1 enabled cycles); on each tick the
// main counter steps up or down inside 0..period and wraps, pulsing overflow
// (up-count wrap period->0) or underflow (down-count wrap 0->period) for one
// cycle in the same cycle the wrapped value appears on counter_val.
//
// Configuration macro:
//   PWM_COUNTER_SHADOW_EN  defined   : period, prescale and upnotdown are
//                                      latched into active shadow registers
//                                      only while en=0, during count_reset, or
//                                      on the cycle a wrap occurs, so a new
//                                      configuration takes effect at a clean
//                                      period boundary.
//                          undefined : the inputs are used directly every
//                                      cycle; out-of-range state left behind
//                                      by a live change is recovered on the
//                                      next tick.
//
// Ports:
//   clk          in   1   peripheral clock, rising-edge
//   rst_n        in   1   asynchronous active-low reset
//   period       in  16   inclusive terminal count value
//   en           in   1   count enable; 0 freezes counter and prescaler
//   count_reset  in   1   synchronous level-sensitive clear, highest priority
//   upnotdown    in   1   1 = count up, 0 = count down
//   prescale     in   8   tick divider (tick every prescale+1 cycles)
//   counter_val  out 16   current count, registered
//   overflow     out  1   one-cycle pulse on up-count wrap
//   underflow    out  1   one-cycle pulse on down-count wrap
// -----------------------------------------------------------------------------
module pwm_counter (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] period,
    input  logic        en,
    input  logic        count_reset,
    input  logic        upnotdown,
    input  logic [7:0]  prescale,
    output logic [15:0] counter_val,
    output logic        overflow,
    output logic        underflow
);

    // Prescaler state and the configuration actually governing the count.
    logic [7:0]  psc_cnt;
    logic [15:0] act_period;
    logic [7:0]  act_prescale;
    logic        act_up;

    // Next-state values computed combinationally, registered below.
    logic [7:0]  psc_nxt;
    logic [15:0] cnt_nxt;
    logic        ovf_nxt;
    logic        unf_nxt;
    logic        tick;
    logic        wrap;

`ifdef PWM_COUNTER_SHADOW_EN
    logic        shadow_load;

    // Shadows follow the inputs only at safe points, so a period in progress
    // always completes with the configuration it started with.
    assign shadow_load = !en || count_reset || wrap;

    // NOTE: configuration shadows are ordinary control registers and get an
    // async reset so the counter starts from a defined period/prescale/direction.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            act_period   <= '0;
            act_prescale <= '0;
            act_up       <= 1'b1;
        end else if (shadow_load) begin
            act_period   <= period;
            act_prescale <= prescale;
            act_up       <= upnotdown;
        end
    end
`else
    assign act_period   = period;
    assign act_prescale = prescale;
    assign act_up       = upnotdown;
`endif

    assign wrap = ovf_nxt || unf_nxt;

    // NOTE: every variable written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        tick    = 1'b0;
        psc_nxt = psc_cnt;
        cnt_nxt = counter_val;
        ovf_nxt = 1'b0;
        unf_nxt = 1'b0;

        if (count_reset) begin
            // Clear wins over enable and over a coincident wrap: no pulse.
            psc_nxt = '0;
            cnt_nxt = '0;
        end else if (en) begin
            // Prescaler. A live prescale reduction can leave psc_cnt above the
            // terminal value; restart from 0 rather than running to 255.
            if (psc_cnt > act_prescale) begin
                psc_nxt = '0;
            end else if (psc_cnt == act_prescale) begin
                psc_nxt = '0;
                tick    = 1'b1;
            end else begin
                psc_nxt = psc_cnt + 8'd1;
            end

            if (tick) begin
                if (act_up) begin
                    // >= rather than == also recovers from a period shrunk
                    // below the current count.
                    if (counter_val >= act_period) begin
                        cnt_nxt = '0;
                        ovf_nxt = 1'b1;
                    end else begin
                        cnt_nxt = counter_val + 16'd1;
                    end
                end else begin
                    if (counter_val == 16'd0) begin
                        // Reload from the period input: identical to the
                        // active period when unshadowed, and equal to the
                        // value being latched this cycle when shadowed.
                        cnt_nxt = period;
                        unf_nxt = 1'b1;
                    end else if (counter_val > act_period) begin
                        // Out of range after a period change: clamp, no pulse.
                        cnt_nxt = act_period;
                    end else begin
                        cnt_nxt = counter_val - 16'd1;
                    end
                end
            end
        end
    end

    // NOTE: sequential state is written with non-blocking assignments only, so
    // every register samples the pre-edge values regardless of block order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            psc_cnt     <= '0;
            counter_val <= '0;
            overflow    <= 1'b0;
            underflow   <= 1'b0;
        end else begin
            psc_cnt     <= psc_nxt;
            counter_val <= cnt_nxt;
            overflow    <= ovf_nxt;
            underflow   <= unf_nxt;
        end
    end

endmodule
